// File: rtl/sun_pll_rosc_cal.sv
// sun_pll_rosc_cal: ring-oscillator frequency calibration controller.
// Counts synchronised oscillator edges over a fixed reference window.
// The trim code is first found by binary search, MSB first. It is then
// held by +/-1 closed-loop tracking against a tolerance band around the
// target edge count. LOCK is flagged after LOCK_N consecutive in-band windows.
module sun_pll_rosc_cal #(
  parameter int TRIM_W     = 5,
  parameter int CNT_W      = 12,
  parameter int WINDOW     = 256,
  parameter int SETTLE_CYC = 16,
  parameter int TOL        = 2,
  parameter int LOCK_N     = 4
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              PWRUP,
  input  logic              CKOSC_EDGE,
  input  logic [CNT_W-1:0]  TARGET,
  output logic              PWRUP_OSC,
  output logic [TRIM_W-1:0] TRIM,
  output logic [CNT_W-1:0]  CNT_LAST,
  output logic              BUSY,
  output logic              LOCK
);

  localparam int CYC_MAX = (WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int PTR_W   = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam int LCK_W   = $clog2(LOCK_N + 1);

  localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0]  WIN_LAST    = CYC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [TRIM_W-1:0] TRIM_MAX    = {TRIM_W{1'b1}};
  localparam logic [TRIM_W-1:0] TRIM_MID    = TRIM_W'(1) << (TRIM_W - 1);
  localparam logic [PTR_W-1:0]  PTR_TOP     = PTR_W'(TRIM_W - 1);
  localparam logic [LCK_W-1:0]  LOCK_FULL   = LCK_W'(LOCK_N);
  localparam logic [CNT_W:0]    TOL_EXT     = (CNT_W + 1)'(TOL);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_SETTLE       = 3'd1,
    ST_MEASURE      = 3'd2,
    ST_EVAL         = 3'd3,
    ST_TRACK_SETTLE = 3'd4,
    ST_TRACK_MEAS   = 3'd5,
    ST_TRACK_EVAL   = 3'd6
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  target_r;
  logic [TRIM_W-1:0] trim_r;
  logic [PTR_W-1:0]  bit_ptr_r;
  logic [CYC_W-1:0]  cyc_cnt_r;
  logic [CNT_W-1:0]  edge_cnt_r;
  logic [CNT_W-1:0]  cnt_last_r;
  logic [LCK_W-1:0]  inband_cnt_r;
  logic              lock_r;
  logic              busy_r;
  logic              pwrup_osc_r;

  logic [CNT_W-1:0]  edge_inc_s;
  logic              ge_s;
  logic [TRIM_W-1:0] bit_mask_s;
  logic [TRIM_W-1:0] next_mask_s;
  logic [TRIM_W-1:0] trim_eval_s;
  logic [CNT_W:0]    target_ext_s;
  logic [CNT_W:0]    count_ext_s;
  logic [CNT_W:0]    band_lo_s;
  logic [CNT_W:0]    band_sum_s;
  logic [CNT_W:0]    band_hi_s;
  logic              below_s;
  logic              above_s;
  logic              in_band_s;
  logic [TRIM_W-1:0] trim_track_s;
  logic [LCK_W-1:0]  inband_inc_s;

  // Saturating edge count, binary-search trim step and tracking band decisions.
  always_comb begin
    edge_inc_s   = (CKOSC_EDGE && (edge_cnt_r != CNT_MAX)) ? (edge_cnt_r + CNT_W'(1)) : edge_cnt_r;
    ge_s         = (edge_cnt_r >= target_r);
    bit_mask_s   = TRIM_W'(1) << bit_ptr_r;
    next_mask_s  = bit_mask_s >> 1;
    trim_eval_s  = (ge_s ? (trim_r & ~bit_mask_s) : trim_r) | next_mask_s;
    target_ext_s = {1'b0, target_r};
    count_ext_s  = {1'b0, edge_cnt_r};
    band_lo_s    = (target_ext_s >= TOL_EXT) ? (target_ext_s - TOL_EXT) : '0;
    band_sum_s   = target_ext_s + TOL_EXT;
    band_hi_s    = (band_sum_s > {1'b0, CNT_MAX}) ? {1'b0, CNT_MAX} : band_sum_s;
    below_s      = (count_ext_s < band_lo_s);
    above_s      = (count_ext_s > band_hi_s);
    in_band_s    = !below_s && !above_s;
    if (below_s) begin
      trim_track_s = (trim_r == TRIM_MAX) ? trim_r : (trim_r + TRIM_W'(1));
    end else if (above_s) begin
      trim_track_s = (trim_r == '0) ? trim_r : (trim_r - TRIM_W'(1));
    end else begin
      trim_track_s = trim_r;
    end
    inband_inc_s = (inband_cnt_r == LOCK_FULL) ? inband_cnt_r : (inband_cnt_r + LCK_W'(1));
  end

  // Calibration sequencer: search, tracking, lock and all registered outputs.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_r      <= ST_IDLE;
      target_r     <= '0;
      trim_r       <= '0;
      bit_ptr_r    <= '0;
      cyc_cnt_r    <= '0;
      edge_cnt_r   <= '0;
      cnt_last_r   <= '0;
      inband_cnt_r <= '0;
      lock_r       <= 1'b0;
      busy_r       <= 1'b0;
      pwrup_osc_r  <= 1'b0;
    end else if (!PWRUP) begin
      state_r      <= ST_IDLE;
      target_r     <= '0;
      trim_r       <= '0;
      bit_ptr_r    <= '0;
      cyc_cnt_r    <= '0;
      edge_cnt_r   <= '0;
      cnt_last_r   <= '0;
      inband_cnt_r <= '0;
      lock_r       <= 1'b0;
      busy_r       <= 1'b0;
      pwrup_osc_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          target_r     <= TARGET;
          trim_r       <= TRIM_MID;
          bit_ptr_r    <= PTR_TOP;
          cyc_cnt_r    <= '0;
          inband_cnt_r <= '0;
          lock_r       <= 1'b0;
          busy_r       <= 1'b1;
          pwrup_osc_r  <= 1'b1;
          state_r      <= ST_SETTLE;
        end
        ST_SETTLE, ST_TRACK_SETTLE: begin
          if (cyc_cnt_r == SETTLE_LAST) begin
            cyc_cnt_r  <= '0;
            edge_cnt_r <= '0;
            state_r    <= (state_r == ST_SETTLE) ? ST_MEASURE : ST_TRACK_MEAS;
          end else begin
            cyc_cnt_r  <= cyc_cnt_r + CYC_W'(1);
          end
        end
        ST_MEASURE, ST_TRACK_MEAS: begin
          edge_cnt_r <= edge_inc_s;
          if (cyc_cnt_r == WIN_LAST) begin
            cyc_cnt_r <= '0;
            state_r   <= (state_r == ST_MEASURE) ? ST_EVAL : ST_TRACK_EVAL;
          end else begin
            cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
          end
        end
        ST_EVAL: begin
          cnt_last_r <= edge_cnt_r;
          trim_r     <= trim_eval_s;
          if (bit_ptr_r != '0) begin
            bit_ptr_r <= bit_ptr_r - PTR_W'(1);
            state_r   <= ST_SETTLE;
          end else begin
            state_r   <= ST_TRACK_SETTLE;
          end
        end
        ST_TRACK_EVAL: begin
          cnt_last_r <= edge_cnt_r;
          trim_r     <= trim_track_s;
          if (in_band_s) begin
            inband_cnt_r <= inband_inc_s;
            lock_r       <= (inband_inc_s == LOCK_FULL);
          end else begin
            inband_cnt_r <= '0;
            lock_r       <= 1'b0;
          end
          state_r <= ST_TRACK_SETTLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          trim_r       <= '0;
          cnt_last_r   <= '0;
          inband_cnt_r <= '0;
          lock_r       <= 1'b0;
          busy_r       <= 1'b0;
          pwrup_osc_r  <= 1'b0;
        end
      endcase
    end
  end

  assign PWRUP_OSC = pwrup_osc_r;
  assign TRIM      = trim_r;
  assign CNT_LAST  = cnt_last_r;
  assign BUSY      = busy_r;
  assign LOCK      = lock_r;

endmodule

// File: tb/tb_sun_pll_rosc_cal.sv
// Testbench for sun_pll_rosc_cal: oscillator model with gain*TRIM edges per
// window, a table of directed cases, an abstract search/track reference
// model, hand-written abort/reset/gain-step sequences and a saturation
// instance.
module tb_sun_pll_rosc_cal;
  localparam int TRIM_W = 5;
  localparam int CNT_W  = 12;
  localparam int WINDOW = 256;
  localparam int SETTLE = 16;
  localparam int TOL    = 2;
  localparam int LOCK_N = 4;
  localparam int STEP   = SETTLE + WINDOW + 1;

  logic              ck, rstn, pwrup, ckosc_edge;
  logic [CNT_W-1:0]  target;
  logic              pwrup_osc, busy, lock;
  logic [TRIM_W-1:0] trim;
  logic [CNT_W-1:0]  cnt_last;

  logic              pwrup2, edge2;
  logic [7:0]        target2;
  logic              pwrup_osc2, busy2, lock2;
  logic [TRIM_W-1:0] trim2;
  logic [7:0]        cnt_last2;

  int n_chk = 0;
  int n_fail = 0;
  int gain = 0;
  int m_target, m_t, m_inb;

  typedef struct {
    int tgt; int g; int s_trim; int s_cnt; int n_track; int f_trim; int f_cnt; int f_lock;
  } vec_t;
  vec_t tbl[3];

  sun_pll_rosc_cal dut (
    .CK(ck), .RSTN(rstn), .PWRUP(pwrup), .CKOSC_EDGE(ckosc_edge), .TARGET(target),
    .PWRUP_OSC(pwrup_osc), .TRIM(trim), .CNT_LAST(cnt_last), .BUSY(busy), .LOCK(lock)
  );

  sun_pll_rosc_cal #(.CNT_W(8), .WINDOW(300)) dut_sat (
    .CK(ck), .RSTN(rstn), .PWRUP(pwrup2), .CKOSC_EDGE(edge2), .TARGET(target2),
    .PWRUP_OSC(pwrup_osc2), .TRIM(trim2), .CNT_LAST(cnt_last2), .BUSY(busy2), .LOCK(lock2)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Oscillator model: phase accumulator giving exactly min(gain*TRIM, WINDOW)
  // pulses over any WINDOW consecutive cycles with a constant rate.
  initial begin
    int acc;
    int n;
    acc = 0;
    ckosc_edge = 1'b0;
    forever begin
      @(negedge ck);
      n = gain * int'(trim);
      if (n >= WINDOW) begin
        ckosc_edge = 1'b1;
      end else begin
        acc = acc + n;
        if (acc >= WINDOW) begin
          acc = acc - WINDOW;
          ckosc_edge = 1'b1;
        end else begin
          ckosc_edge = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int f_count(input int t, input int g);
    int c;
    c = g * t;
    if (c > WINDOW) c = WINDOW;
    if (c > 4095) c = 4095;
    return c;
  endfunction

  task automatic wait_step();
    repeat (STEP) @(posedge ck);
    @(negedge ck);
  endtask

  task automatic stop_cal();
    pwrup = 1'b0;
    @(posedge ck);
    @(negedge ck);
    check("stop_busy", busy, 0);
  endtask

  task automatic start_search(input int tgt);
    target = CNT_W'(tgt);
    pwrup = 1'b1;
    m_target = tgt;
    m_t = 1 << (TRIM_W - 1);
    m_inb = 0;
    @(posedge ck);
    @(negedge ck);
    target = CNT_W'($urandom);
    check("start_busy", busy, 1);
    check("start_osc", pwrup_osc, 1);
    check("start_trim", trim, 16);
    check("start_lock", lock, 0);
  endtask

  // Model search: MSB-first trial bits, clear when count >= target.
  task automatic search_steps();
    int c;
    for (int b = TRIM_W - 1; b >= 0; b--) begin
      wait_step();
      c = f_count(m_t, gain);
      if (c >= m_target) m_t = m_t & ~(1 << b);
      if (b > 0) m_t = m_t | (1 << (b - 1));
      check($sformatf("srch_trim[b%0d]", b), trim, m_t);
      check($sformatf("srch_cnt[b%0d]", b), cnt_last, c);
      check($sformatf("srch_lock[b%0d]", b), lock, 0);
    end
  endtask

  // Model tracking: +/-1 outside [target-TOL, target+TOL], lock after LOCK_N in band.
  task automatic track_steps(input int n);
    int c, lo, hi;
    lo = (m_target - TOL < 0) ? 0 : m_target - TOL;
    hi = (m_target + TOL > 4095) ? 4095 : m_target + TOL;
    for (int w = 0; w < n; w++) begin
      wait_step();
      c = f_count(m_t, gain);
      if (c < lo) begin
        m_t = (m_t + 1 > 31) ? 31 : m_t + 1;
        m_inb = 0;
      end else if (c > hi) begin
        m_t = (m_t - 1 < 0) ? 0 : m_t - 1;
        m_inb = 0;
      end else begin
        m_inb = (m_inb + 1 > LOCK_N) ? LOCK_N : m_inb + 1;
      end
      check($sformatf("trk_trim[w%0d]", w), trim, m_t);
      check($sformatf("trk_cnt[w%0d]", w), cnt_last, c);
      check($sformatf("trk_lock[w%0d]", w), lock, (m_inb == LOCK_N) ? 1 : 0);
    end
  endtask

  initial begin
    tbl[0] = '{tgt: 155,  g: 5,  s_trim: 30, s_cnt: 155, n_track: 5, f_trim: 31, f_cnt: 155, f_lock: 1};
    tbl[1] = '{tgt: 4095, g: 10, s_trim: 31, s_cnt: 256, n_track: 3, f_trim: 31, f_cnt: 256, f_lock: 0};
    tbl[2] = '{tgt: 0,    g: 5,  s_trim: 0,  s_cnt: 5,   n_track: 4, f_trim: 0,  f_cnt: 0,   f_lock: 1};

    rstn = 1'b0; pwrup = 1'b0; target = '0;
    pwrup2 = 1'b0; edge2 = 1'b1; target2 = 8'd100;
    repeat (3) @(negedge ck);
    check("rst_busy", busy, 0);
    check("rst_osc", pwrup_osc, 0);
    check("rst_trim", trim, 0);
    check("rst_cnt", cnt_last, 0);
    check("rst_lock", lock, 0);
    rstn = 1'b1;
    @(negedge ck);

    // Saturating counter: edges every cycle over a 300-cycle window, 8-bit count.
    pwrup2 = 1'b1;
    @(posedge ck);
    @(negedge ck);
    repeat (SETTLE + 300 + 1) @(posedge ck);
    @(negedge ck);
    check("sat_cnt", cnt_last2, 255);
    check("sat_trim", trim2, 8);
    pwrup2 = 1'b0;

    // Directed table.
    for (int i = 0; i < 3; i++) begin
      gain = tbl[i].g;
      start_search(tbl[i].tgt);
      search_steps();
      check($sformatf("tbl%0d_s_trim", i), trim, tbl[i].s_trim);
      check($sformatf("tbl%0d_s_cnt", i), cnt_last, tbl[i].s_cnt);
      track_steps(tbl[i].n_track);
      check($sformatf("tbl%0d_f_trim", i), trim, tbl[i].f_trim);
      check($sformatf("tbl%0d_f_cnt", i), cnt_last, tbl[i].f_cnt);
      check($sformatf("tbl%0d_f_lock", i), lock, tbl[i].f_lock);
      stop_cal();
    end

    // Gain step while locked at TRIM=31.
    gain = 5;
    start_search(155);
    search_steps();
    track_steps(5);
    check("gstep_pre_lock", lock, 1);
    gain = 6;
    track_steps(1);
    check("gstep_trim", trim, 30);
    check("gstep_cnt", cnt_last, 186);
    check("gstep_lock", lock, 0);
    track_steps(1);
    check("gstep_trim2", trim, 29);
    stop_cal();

    // Abort mid-MEASURE of the third search step, then restart with a new target.
    gain = 5;
    start_search(155);
    wait_step();
    wait_step();
    repeat (SETTLE + 100) @(posedge ck);
    @(negedge ck);
    pwrup = 1'b0;
    @(posedge ck);
    @(negedge ck);
    check("abort_busy", busy, 0);
    check("abort_osc", pwrup_osc, 0);
    check("abort_trim", trim, 0);
    check("abort_cnt", cnt_last, 0);
    @(negedge ck);
    start_search(0);
    search_steps();
    check("restart_trim", trim, 0);

    // Asynchronous reset between clock edges.
    #2;
    rstn = 1'b0;
    pwrup = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_osc", pwrup_osc, 0);
    check("arst_trim", trim, 0);
    check("arst_cnt", cnt_last, 0);
    @(negedge ck);
    rstn = 1'b1;
    @(negedge ck);

    // Randomised targets and oscillator gains against the reference model.
    for (int r = 0; r < 4; r++) begin
      gain = $urandom_range(10, 1);
      start_search($urandom_range(320, 0));
      search_steps();
      track_steps(6);
      stop_cal();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
